// File: rtl/gift_pipe_ctrl.sv
// Admission, tracking and credit sequencer for the free-running GIFT-128 round pipeline.
// Valid/tag shift alongside the datapath; credits mirror free downstream result slots.
module gift_pipe_ctrl #(
  parameter int LATENCY = 40,
  parameter int TAG_W   = 4,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 6
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inStart,
  output logic             outReady,
  input  logic [TAG_W-1:0] inTag,
  output logic             outLoad,
  output logic             outWr,
  output logic [TAG_W-1:0] outTag,
  input  logic             inCreditRet,
  input  logic             inFlush,
  output logic [CNT_W-1:0] outInFlight,
  output logic [CNT_W-1:0] outCredits,
  output logic             outBusy,
  output logic             outOverflow
);

  localparam int               SUM_W     = CNT_W + 1;
  localparam logic [CNT_W-1:0] CRED_FULL = CNT_W'(CREDITS);
  localparam logic [SUM_W-1:0] CRED_SUM  = SUM_W'(CREDITS);

  logic [LATENCY-1:0] vldSr;
  logic [TAG_W-1:0]   tagSr [LATENCY];
  logic [CNT_W-1:0]   inFlight;
  logic [CNT_W-1:0]   credits;
  logic               overflow;
  logic               accept;
  logic               exitVld;
  logic [SUM_W-1:0]   flushSum;

  // Flush returns every in-flight credit; clamp to the buffer size.
  function automatic logic [CNT_W-1:0] satCredits(input logic [SUM_W-1:0] sum);
    if (sum > CRED_SUM)
      return CRED_FULL;
    else
      return sum[CNT_W-1:0];
  endfunction

  assign outReady = (credits != '0) & ~inFlush & inRstN;
  assign accept   = inStart & outReady;
  assign outLoad  = accept;
  assign exitVld  = vldSr[LATENCY-1];
  assign outWr    = exitVld & ~inFlush & inRstN;
  assign outTag   = outWr ? tagSr[LATENCY-1] : '0;
  assign flushSum = {1'b0, credits} + {1'b0, inFlight} + SUM_W'(inCreditRet);

  // Stage tracking: one slot per pipeline cycle, no stall path.
  always_ff @(posedge inClk) begin
    if (!inRstN || inFlush) begin
      vldSr <= '0;
      for (int i = 0; i < LATENCY; i++) tagSr[i] <= '0;
    end else begin
      vldSr    <= {vldSr[LATENCY-2:0], accept};
      tagSr[0] <= accept ? inTag : '0;
      for (int i = 1; i < LATENCY; i++) tagSr[i] <= tagSr[i-1];
    end
  end

  // Counters: credit is taken at accept and only given back by the downstream buffer or a flush.
  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      inFlight <= '0;
      credits  <= CRED_FULL;
      overflow <= 1'b0;
    end else if (inFlush) begin
      inFlight <= '0;
      credits  <= satCredits(flushSum);
      if (flushSum > CRED_SUM) overflow <= 1'b1;
    end else begin
      inFlight <= inFlight + CNT_W'(accept) - CNT_W'(exitVld);
      if (inCreditRet && !accept && (credits == CRED_FULL))
        overflow <= 1'b1;
      else
        credits <= credits + CNT_W'(inCreditRet) - CNT_W'(accept);
    end
  end

  assign outInFlight = inFlight;
  assign outCredits  = credits;
  assign outBusy     = (inFlight != '0);
  assign outOverflow = overflow;

endmodule

// File: tb/tb_gift_pipe_ctrl.sv
// Randomized and directed stimulus against a queue-based model of admitted blocks and credits.
module tb_gift_pipe_ctrl;
  localparam int LATENCY = 40;
  localparam int TAG_W   = 4;
  localparam int CREDITS = 4;
  localparam int CNT_W   = 6;

  logic             clk = 1'b0;
  logic             rstN, start, ret, flush;
  logic [TAG_W-1:0] tag;
  logic             outReady, outLoad, outWr, outBusy, outOverflow;
  logic [TAG_W-1:0] outTag;
  logic [CNT_W-1:0] outInFlight, outCredits;

  typedef struct {
    int               exitCyc;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mCred = CREDITS;
  bit   mOvf = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gift_pipe_ctrl #(.LATENCY(LATENCY), .TAG_W(TAG_W), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .inClk(clk), .inRstN(rstN), .inStart(start), .outReady(outReady), .inTag(tag),
    .outLoad(outLoad), .outWr(outWr), .outTag(outTag), .inCreditRet(ret), .inFlush(flush),
    .outInFlight(outInFlight), .outCredits(outCredits), .outBusy(outBusy),
    .outOverflow(outOverflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT against the model mid-cycle, then advance the model.
  bit   expRdy, expAcc, expWr;
  int   sum;
  ent_t e;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      expRdy = rstN && (mCred != 0) && !flush;
      expAcc = expRdy && start;
      chk("outCredits", int'(outCredits), mCred);
      chk("outInFlight", int'(outInFlight), sb.size());
      chk("outBusy", int'(outBusy), int'(sb.size() != 0));
      chk("outOverflow", int'(outOverflow), int'(mOvf));
      chk("outReady", int'(outReady), int'(expRdy));
      chk("outLoad", int'(outLoad), int'(expAcc));
      expWr = rstN && !flush && (sb.size() > 0) && (sb[0].exitCyc == cyc);
      chk("outWr", int'(outWr), int'(expWr));
      if (expWr) begin
        chk("outTag", int'(outTag), int'(sb[0].tag));
        void'(sb.pop_front());
      end else begin
        chk("outTagIdle", int'(outTag), 0);
      end
      if (!rstN) begin
        sb.delete();
        mCred = CREDITS;
        mOvf  = 1'b0;
      end else if (flush) begin
        sum = mCred + sb.size() + int'(ret);
        if (sum > CREDITS) begin
          mCred = CREDITS;
          mOvf  = 1'b1;
        end else begin
          mCred = sum;
        end
        sb.delete();
      end else begin
        if (ret && !expAcc && mCred == CREDITS) mOvf = 1'b1;
        else mCred = mCred + int'(ret) - int'(expAcc);
        if (expAcc) begin
          e.exitCyc = cyc + LATENCY;
          e.tag     = tag;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic step(input bit s, input logic [TAG_W-1:0] t, input bit r, input bit f, input bit rn);
    start = s; tag = t; ret = r; flush = f; rstN = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    start = 1'b0; tag = '0; ret = 1'b0; flush = 1'b0; rstN = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    // single block with tag 5
    idle(6);
    step(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    idle(45);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    // start held high: only CREDITS accepts, then back-to-back writes
    repeat (8) step(1'b1, TAG_W'($urandom), 1'b0, 1'b0, 1'b1);
    idle(44);
    // return with start held, then simultaneous accept and return
    step(1'b1, 4'd9, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'd10, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'd11, 1'b1, 1'b0, 1'b1);
    idle(45);
    // flush with three blocks in flight
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, TAG_W'(i + 1), 1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
    idle(45);
    // reset with two blocks in flight
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd12, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd13, 1'b0, 1'b0, 1'b1);
    idle(10);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(45);
    // credit return while full: sticky overflow
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(5);
    // randomized traffic
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom % 2), TAG_W'($urandom), 1'(($urandom % 4) == 0),
           1'(($urandom % 64) == 0), 1'(($urandom % 256) != 0));
    idle(50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
